// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: op codes, exception codes,
// FSM encodings and access-size helpers.
package mem_access_unit_pkg;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWU = 4'd5;
    localparam logic [3:0] OP_LD  = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;
    localparam logic [3:0] OP_SD  = 4'd11;
    localparam logic [3:0] OP_LL  = 4'd12;
    localparam logic [3:0] OP_SC  = 4'd13;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_BUS  = 5'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic bit data_w_legal(int w);
        return (w == 32) || (w == 64);
    endfunction

    function automatic logic op_is_store(logic [3:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) ||
               (op == OP_SD) || (op == OP_SC);
    endfunction

    // Access size in bytes; 0 marks the NOP class (including LD/SD on a 32-bit path).
    function automatic logic [3:0] op_bytes(logic [3:0] op, logic wide);
        case (op)
            OP_LB, OP_LBU, OP_SB:               return 4'd1;
            OP_LH, OP_LHU, OP_SH:               return 4'd2;
            OP_LW, OP_LWU, OP_SW, OP_LL, OP_SC: return 4'd4;
            OP_LD, OP_SD:                       return wide ? 4'd8 : 4'd0;
            default:                            return 4'd0;
        endcase
    endfunction

    function automatic logic misaligned(logic [3:0] nbytes, logic [2:0] lo);
        case (nbytes)
            4'd2:    return lo[0];
            4'd4:    return |lo[1:0];
            4'd8:    return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_fmt.sv
// Combinational lane handling: load extract + sign/zero extend, store
// replication and byte-select generation from op and byte offset.
module mem_lane_fmt
    import mem_access_unit_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int SEL_W  = DATA_W / 8,
    localparam int OFF_W  = $clog2(SEL_W)
) (
    input  logic [3:0]        op_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] load_o,
    output logic [DATA_W-1:0] store_o,
    output logic [SEL_W-1:0]  sel_o
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        load_o  = '0;
        store_o = '0;
        sel_o   = '0;
        case (op_i)
            OP_LB:        load_o = DATA_W'($signed(shifted[7:0]));
            OP_LBU:       load_o = DATA_W'(shifted[7:0]);
            OP_LH:        load_o = DATA_W'($signed(shifted[15:0]));
            OP_LHU:       load_o = DATA_W'(shifted[15:0]);
            OP_LW, OP_LL: load_o = DATA_W'($signed(shifted[31:0]));
            OP_LWU:       load_o = DATA_W'(shifted[31:0]);
            OP_LD:        load_o = shifted;
            OP_SB:        store_o = {SEL_W{wdata_i[7:0]}};
            OP_SH:        store_o = {(SEL_W / 2){wdata_i[15:0]}};
            OP_SW, OP_SC: store_o = {(SEL_W / 4){wdata_i[31:0]}};
            OP_SD:        store_o = wdata_i;
            default:      ;
        endcase
        case (op_i)
            OP_LB, OP_LBU, OP_SB:               sel_o = SEL_W'(1) << off_i;
            OP_LH, OP_LHU, OP_SH:               sel_o = SEL_W'(2'b11) << off_i;
            OP_LW, OP_LWU, OP_LL, OP_SW, OP_SC: sel_o = SEL_W'(4'hF) << off_i;
            OP_LD, OP_SD:                       sel_o = '1;
            default:                            ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle MEM-stage access unit: IDLE/BUS/RESP FSM driving a ready/ack bus,
// with bus timeout and LL/SC reservation tracking.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    input  logic [3:0]          op_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                flush_i,
    output logic                stallreq_o,
    output logic                done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic [4:0]          excode_o,
    output logic                llbit_o,
    output logic                bus_req_o,
    output logic                bus_we_o,
    output logic [DATA_W/8-1:0] bus_sel_o,
    output logic [ADDR_W-1:0]   bus_addr_o,
    output logic [DATA_W-1:0]   bus_wdata_o,
    input  logic                bus_ack_i,
    input  logic [DATA_W-1:0]   bus_rdata_i
);

    localparam int   SEL_W = DATA_W / 8;
    localparam int   OFF_W = $clog2(SEL_W);
    localparam int   CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic WIDE  = (DATA_W == 64);

    generate
        if (!data_w_legal(DATA_W)) begin : g_bad_data_w
            $error("mem_access_unit: DATA_W must be 32 or 64");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                drop_q, drop_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [4:0]          exc_q, exc_d;
    logic                llbit_q, llbit_d;
    logic [ADDR_W-3:0]   res_q, res_d;

    logic                idle, accept, req_mis, timeout_hit, drop, store_hit;
    logic [3:0]          req_bytes;
    logic [3:0]          fmt_op;
    logic [OFF_W-1:0]    fmt_off;
    logic [DATA_W-1:0]   fmt_load, fmt_store;
    logic [SEL_W-1:0]    fmt_sel;

    // One formatter serves both phases: request fields in IDLE, latched fields in BUS.
    assign idle    = (state_q == ST_IDLE);
    assign fmt_op  = idle ? op_i : op_q;
    assign fmt_off = idle ? addr_i[OFF_W-1:0] : addr_q[OFF_W-1:0];

    mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
        .op_i    (fmt_op),
        .off_i   (fmt_off),
        .wdata_i (wdata_i),
        .rdata_i (bus_rdata_i),
        .load_o  (fmt_load),
        .store_o (fmt_store),
        .sel_o   (fmt_sel)
    );

    assign req_bytes   = op_bytes(op_i, WIDE);
    assign req_mis     = misaligned(req_bytes, addr_i[2:0]);
    assign accept      = idle && req_valid_i && !flush_i && (req_bytes != 4'd0);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign drop        = drop_q || flush_i;
    assign store_hit   = op_is_store(op_q) && (addr_q[ADDR_W-1:2] == res_q);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        llbit_d = llbit_q;
        res_d   = res_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                drop_d = 1'b0;
                if (accept) begin
                    op_d    = op_i;
                    addr_d  = addr_i;
                    we_d    = op_is_store(op_i);
                    wdata_d = fmt_store;
                    sel_d   = fmt_sel;
                    rdata_d = '0;
                    exc_d   = EXC_NONE;
                    if (req_mis) begin
                        exc_d   = op_is_store(op_i) ? EXC_ADES : EXC_ADEL;
                        state_d = ST_RESP;
                    end else if (op_i == OP_SC && !llbit_q) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUS;
                    end
                end
            end
            ST_BUS: begin
                drop_d = drop;
                // Ack wins over a coincident timeout.
                if (bus_ack_i) begin
                    state_d = drop ? ST_IDLE : ST_RESP;
                    if (!drop) begin
                        if (op_q == OP_SC)  rdata_d = DATA_W'(1);
                        else if (we_q)      rdata_d = '0;
                        else                rdata_d = fmt_load;
                        if (op_q == OP_LL) begin
                            llbit_d = 1'b1;
                            res_d   = addr_q[ADDR_W-1:2];
                        end else if (op_q == OP_SC || store_hit) begin
                            llbit_d = 1'b0;
                        end
                    end
                end else if (timeout_hit) begin
                    state_d = drop ? ST_IDLE : ST_RESP;
                    exc_d   = EXC_BUS;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            rdata_q <= '0;
            exc_q   <= EXC_NONE;
            llbit_q <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
            llbit_q <= llbit_d;
            res_q   <= res_d;
        end
    end

    assign stallreq_o  = accept || (state_q == ST_BUS);
    assign done_o      = (state_q == ST_RESP) && !flush_i;
    assign rdata_o     = done_o ? rdata_q : '0;
    assign excode_o    = done_o ? exc_q : EXC_NONE;
    assign llbit_o     = llbit_q;
    assign bus_req_o   = (state_q == ST_BUS);
    assign bus_we_o    = bus_req_o && (we_q == WriteEnable);
    assign bus_sel_o   = bus_req_o ? sel_q : '0;
    assign bus_addr_o  = bus_req_o ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus_wdata_o = bus_req_o ? wdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: 32-bit instance (TIMEOUT=4) and 64-bit instance.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // 32-bit instance
    logic        req_valid, flush, ack;
    logic [3:0]  op;
    logic [31:0] addr, wdata, bus_rdata;
    logic        stallreq, done, llbit, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [4:0]  excode;
    logic [3:0]  bus_sel;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .op_i(op), .addr_i(addr),
        .wdata_i(wdata), .flush_i(flush), .stallreq_o(stallreq), .done_o(done),
        .rdata_o(rdata), .excode_o(excode), .llbit_o(llbit), .bus_req_o(bus_req),
        .bus_we_o(bus_we), .bus_sel_o(bus_sel), .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata), .bus_ack_i(ack), .bus_rdata_i(bus_rdata)
    );

    // 64-bit instance
    logic        req_valid_w, flush_w, ack_w;
    logic [3:0]  op_w;
    logic [31:0] addr_w, bus_addr_w;
    logic [63:0] wdata_w, bus_rdata_w, rdata_w, bus_wdata_w;
    logic        stallreq_w, done_w, llbit_w, bus_req_w, bus_we_w;
    logic [4:0]  excode_w;
    logic [7:0]  bus_sel_w;

    mem_access_unit #(.DATA_W(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_w), .op_i(op_w), .addr_i(addr_w),
        .wdata_i(wdata_w), .flush_i(flush_w), .stallreq_o(stallreq_w), .done_o(done_w),
        .rdata_o(rdata_w), .excode_o(excode_w), .llbit_o(llbit_w), .bus_req_o(bus_req_w),
        .bus_we_o(bus_we_w), .bus_sel_o(bus_sel_w), .bus_addr_o(bus_addr_w),
        .bus_wdata_o(bus_wdata_w), .bus_ack_i(ack_w), .bus_rdata_i(bus_rdata_w)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0] rdata;
        logic [4:0]  exc;
    } exp_t;
    exp_t sb_q[$];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("rdata", rdata, e.rdata);
                check("excode", excode, e.exc);
            end
        end
    end

    // Issue one request on the 32-bit unit; ack_cyc=0 means the slave never acks.
    task automatic req32(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int ack_cyc,
                         input logic [31:0] exp_rd, input logic [4:0] exp_exc,
                         input int exp_done, input int exp_bus, input logic [3:0] exp_sel,
                         input logic exp_we, input logic [31:0] exp_wd);
        exp_t e;
        int cyc, bus_cycles, done_cyc;
        e.rdata = exp_rd;
        e.exc   = exp_exc;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; op = o; addr = a; wdata = wd;
        #1;
        check({tag, "_stall0"}, stallreq, 1'b1);
        cyc = 0; done_cyc = -1; bus_cycles = 0;
        while (done_cyc < 0 && cyc < 30) begin
            @(posedge clk); #1;
            cyc++;
            req_valid = 1'b0;
            ack       = bus_req && (cyc == ack_cyc);
            bus_rdata = ack ? rd : 32'h0;
            #1;
            if (bus_req) begin
                if (bus_cycles == 0) begin
                    check({tag, "_sel"}, bus_sel, exp_sel);
                    check({tag, "_we"}, bus_we, exp_we);
                    check({tag, "_wdata"}, bus_wdata, exp_wd);
                    check({tag, "_baddr"}, bus_addr, a & 32'hFFFF_FFFC);
                end
                bus_cycles++;
            end
            if (done) begin
                done_cyc = cyc;
                check({tag, "_stall_resp"}, stallreq, 1'b0);
            end
        end
        ack = 1'b0;
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
        check({tag, "_bus_cycles"}, 64'(bus_cycles), 64'(exp_bus));
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        req_valid = 0; flush = 0; ack = 0; op = 0; addr = 0; wdata = 0; bus_rdata = 0;
        req_valid_w = 0; flush_w = 0; ack_w = 0; op_w = 0; addr_w = 0; wdata_w = 0; bus_rdata_w = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_stall", stallreq, 0);
        check("rst_done", done, 0);
        check("rst_busreq", bus_req, 0);
        check("rst_llbit", llbit, 0);
        check("rst_rdata", rdata, 0);
        check("rst_excode", excode, 0);
        check("rst_busaddr", bus_addr, 0);

        req32("lb",   OP_LB,  32'h103, 0, 32'h80FF_1234, 2, 32'hFFFF_FF80, EXC_NONE, 3, 2, 4'b1000, 0, 0);
        req32("sh_mis", OP_SH, 32'h201, 32'h1234, 0, 0, 0, EXC_ADES, 1, 0, 0, 0, 0);
        req32("ll",   OP_LL,  32'h40,  0, 32'h55, 1, 32'h55, EXC_NONE, 2, 1, 4'hF, 0, 0);
        check("ll_llbit", llbit, 1);
        req32("sc_ok", OP_SC, 32'h40, 32'hAA, 0, 1, 32'h1, EXC_NONE, 2, 1, 4'hF, 1, 32'hAA);
        check("sc_llbit", llbit, 0);
        req32("sc_fail", OP_SC, 32'h40, 32'hAA, 0, 1, 32'h0, EXC_NONE, 1, 0, 0, 0, 0);
        req32("ll2",  OP_LL,  32'h40,  0, 32'h77, 1, 32'h77, EXC_NONE, 2, 1, 4'hF, 0, 0);
        check("ll2_llbit", llbit, 1);
        req32("sb_hit", OP_SB, 32'h42, 32'h5A, 0, 1, 32'h0, EXC_NONE, 2, 1, 4'b0100, 1, 32'h5A5A_5A5A);
        check("sb_llbit", llbit, 0);
        req32("sc_fail2", OP_SC, 32'h40, 32'hAA, 0, 1, 32'h0, EXC_NONE, 1, 0, 0, 0, 0);
        req32("lw_to", OP_LW, 32'h100, 0, 0, 0, 32'h0, EXC_BUS, 5, 4, 4'hF, 0, 0);
        req32("lhu",  OP_LHU, 32'h102, 0, 32'h8001_0000, 1, 32'h0000_8001, EXC_NONE, 2, 1, 4'b1100, 0, 0);
        req32("lh",   OP_LH,  32'h102, 0, 32'h8001_0000, 3, 32'hFFFF_8001, EXC_NONE, 4, 3, 4'b1100, 0, 0);
        req32("lbu",  OP_LBU, 32'h101, 0, 32'h0000_9A00, 1, 32'h0000_009A, EXC_NONE, 2, 1, 4'b0010, 0, 0);
        req32("lw_mis", OP_LW, 32'h102, 0, 0, 0, 32'h0, EXC_ADEL, 1, 0, 0, 0, 0);

        // NOP op, LD on a 32-bit path, and flushed request: none may stall or complete
        @(posedge clk); #1 req_valid = 1; op = 4'd7; addr = 32'h0; #1;
        check("nop_stall", stallreq, 0);
        @(posedge clk); #1 op = OP_LD; #1;
        check("ld32_stall", stallreq, 0);
        @(posedge clk); #1 op = OP_LW; flush = 1; #1;
        check("flush_idle_stall", stallreq, 0);
        @(posedge clk); #1 req_valid = 0; flush = 0; #1;
        check("nop_done", done, 0);
        check("nop_busreq", bus_req, 0);

        // Reset while the bus cycle is outstanding
        @(posedge clk); #1 req_valid = 1; op = OP_LW; addr = 32'h300; #1;
        @(posedge clk); #1 req_valid = 0; #1;
        check("rstbus_busreq", bus_req, 1);
        @(posedge clk); #1 rst = 1; #1;
        @(posedge clk); #1 rst = 0; #1;
        check("rstbus_drop", bus_req, 0);
        check("rstbus_stall", stallreq, 0);

        // 64-bit unit: LWU from upper word
        @(posedge clk); #1 req_valid_w = 1; op_w = OP_LWU; addr_w = 32'h14; #1;
        check("w_stall0", stallreq_w, 1);
        @(posedge clk); #1 req_valid_w = 0; ack_w = 1; bus_rdata_w = 64'h8000_0001_1234_5678; #1;
        check("w_lwu_sel", bus_sel_w, 8'hF0);
        check("w_lwu_addr", bus_addr_w, 32'h10);
        @(posedge clk); #1 ack_w = 0; #1;
        check("w_lwu_done", done_w, 1);
        check("w_lwu_rdata", rdata_w, 64'h0000_0000_8000_0001);
        check("w_lwu_exc", excode_w, 0);

        // Flush during BUS: ack arrives, result dropped
        @(posedge clk); #1 req_valid_w = 1; op_w = OP_LD; addr_w = 32'h8; #1;
        ndone = 0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            req_valid_w = 0;
            flush_w     = (c == 1);
            ack_w       = (c == 2);
            bus_rdata_w = 64'h0123_4567_89AB_CDEF;
            #1;
            if (c == 1) check("w_flush_sel", bus_sel_w, 8'hFF);
            if (done_w) ndone++;
        end
        ack_w = 0;
        check("w_flush_ndone", 64'(ndone), 0);
        check("w_flush_idle", bus_req_w, 0);

        // LD after the flush completes normally
        @(posedge clk); #1 req_valid_w = 1; op_w = OP_LD; addr_w = 32'h8; #1;
        @(posedge clk); #1 req_valid_w = 0; ack_w = 1; #1;
        @(posedge clk); #1 ack_w = 0; #1;
        check("w_ld_done", done_w, 1);
        check("w_ld_rdata", rdata_w, 64'h0123_4567_89AB_CDEF);

        // Misaligned dword
        @(posedge clk); #1 req_valid_w = 1; op_w = OP_LD; addr_w = 32'h4; #1;
        @(posedge clk); #1 req_valid_w = 0; #1;
        check("w_ldmis_done", done_w, 1);
        check("w_ldmis_exc", excode_w, EXC_ADEL);
        check("w_ldmis_busreq", bus_req_w, 0);

        repeat (2) @(posedge clk);
        check("sb_drained", 64'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle data-memory access unit for the MEM stage; successor to the purely combinational load/store formatting.
- Accepts one load/store/LL/SC request at a time from the pipeline.
- Drives a variable-latency ready/ack data bus, then returns formatted read data or an exception code.
- Parametrised data width (32/64), bus timeout, and LL/SC reservation tracking; raises a stall request while an access is in flight.

Parameters:
- DATA_W, 32, data path width; legal values 32 or 64 (64 enables LD/SD).
- ADDR_W, 32, address width.
- TIMEOUT, 255, bus-wait cycles before a bus error is declared; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid_i  in  1  request strobe; sampled only in IDLE.
- op_i  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWU, 6 LD, 8 SB, 9 SH, 10 SW, 11 SD, 12 LL, 13 SC; others are NOP.
- addr_i  in  ADDR_W  effective byte address.
- wdata_i  in  DATA_W  store data, right-aligned.
- flush_i  in  1  pipeline flush, discards the current request's result.
- stallreq_o  out  1  stall request to the pipeline controller.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  DATA_W  formatted load result, or SC status (1 = success, 0 = fail).
- excode_o  out  5  0 none, 4 load misaligned, 5 store misaligned, 7 bus error/timeout.
- llbit_o  out  1  reservation valid.
- bus_req_o  out  1  bus request; held until bus_ack_i.
- bus_we_o  out  1  write enable.
- bus_sel_o  out  DATA_W/8  byte lane enables.
- bus_addr_o  out  ADDR_W  bus address, aligned to DATA_W/8.
- bus_wdata_o  out  DATA_W  lane-replicated store data.
- bus_ack_i  in  1  access complete; read data valid in the same cycle.
- bus_rdata_i  in  DATA_W  read data.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, llbit cleared, timeout counter 0.
- FSM states: IDLE, BUS, RESP.
  - IDLE: a valid, non-NOP req_valid_i is latched. Aligned access or successful SC -> BUS. Misaligned access or SC with llbit=0 -> RESP, with no bus cycle.
  - BUS: bus_req_o=1 with address, sel and wdata stable. On bus_ack_i -> RESP, with read data registered. If the counter reaches TIMEOUT -> RESP with excode=7, and bus_req_o drops.
  - RESP: done_o=1 for exactly one cycle, then -> IDLE. A new request is accepted only in the following IDLE cycle.
- Latency: request seen at cycle 0; bus_req_o first high at cycle 1; ack at cycle k gives done_o at k+1. Minimum is 2 cycles with bus access, 1 cycle without.
- stallreq_o: combinationally high while req_valid_i is high in IDLE, and in BUS. Low in RESP, so the pipeline advances with done_o.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; dword requires addr[2:0]=0. Byte accesses are always aligned. LD/SD with DATA_W=32 are treated as NOP.
- Lanes are little-endian: lane index = addr[log2(DATA_W/8)-1:0].
  - Loads: select the lane(s), then sign-extend (LB, LH, LW) or zero-extend (LBU, LHU, LWU) to DATA_W.
  - Stores: replicate data across lanes; bus_sel_o marks only the addressed bytes.
- LL/SC:
  - LL is a word load; on ack it sets llbit and records the reservation address (addr_i word-aligned).
  - SC with llbit=1 performs a word store; on ack it returns rdata=1 and clears llbit.
  - SC with llbit=0 returns rdata=0 with no bus access.
  - Any completed store whose word address matches the reservation clears llbit.
  - On a misaligned access or bus error, llbit is unchanged and rdata_o=0.
- Flush:
  - In IDLE: the request is ignored.
  - In BUS: the bus cycle runs to ack or timeout, but the result is dropped: done_o stays 0 and llbit/reservation are not updated. The FSM returns to IDLE after ack.
  - In RESP: done_o is suppressed.
- Reset mid-BUS: the FSM returns to IDLE and bus_req_o drops the next cycle. The bus slave must tolerate the abandoned request.
- An ack and a timeout in the same cycle count as an ack.

Decomposition:
- Shared package holds:
  - op codes and the NOP class;
  - exception codes 4, 5 and 7;
  - state encodings;
  - the DATA_W legality check;
  - RstEnable / WriteEnable constants.
- One sub-module, mem_lane_fmt: purely combinational load extract/extend and store replicate/sel generation from op, offset and data. The FSM, timeout counter and reservation logic stay in the top module.

Test Plan:
- LB at addr 0x103 with bus_rdata 0x80FF_1234 and 2-cycle ack -> done at cycle 3, rdata 0xFFFF_FF80, excode 0, bus_sel 4'b1000.
- SH at 0x201 -> no bus_req, done at cycle 1, excode 5, stallreq high only in cycle 0.
- LL at 0x40 (rdata 0x55) -> llbit=1. SC at 0x40 with data 0xAA -> bus_we, sel 4'hF, rdata 1, llbit=0. A second SC returns 0 with no bus_req.
- LL at 0x40, then SB at 0x42 -> llbit cleared. The following SC returns 0.
- TIMEOUT=4 with ack never asserted -> bus_req high for cycles 1-4, done at cycle 5, excode 7.
- DATA_W=64: LWU at 0x14 with rdata 0x8000_0001_xxxx_xxxx -> rdata 0x0000_0000_8000_0001. Flush asserted during BUS -> no done_o.
